key_schedule_ctrl: RTL and testbench

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

---
 rtl/key_schedule_ctrl_pkg.sv | 46 ++++
 rtl/key_schedule_ctrl_expand_round.sv | 55 +++++
 rtl/key_schedule_ctrl.sv | 147 ++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_schedule_ctrl_pkg.sv
// Shared definitions for the AES-128 key schedule controller: FSM encoding,
// AES-128 sizing constants and the byte substitution table used by the
// expansion round.
package key_schedule_ctrl_pkg;

  // AES-128 sizing
  localparam int NK           = 4;
  localparam int NR           = 10;
  localparam int NB_ROUNDKEYS = NR + 1;
  localparam int KEY_W        = 128;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  // Forward S-box, entry 0x00 in the MSBs
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Single-byte S-box lookup
  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 255 - int'(b);
    return SBOX_TABLE[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_expand_round.sv
// One combinational AES-128 key expansion round: takes the previous round
// key and the round number (1..10) and produces the next round key. The
// round constant lives here and nowhere else.
module PipelinedKeyExpansionRound
  import key_schedule_ctrl_pkg::*;
(
  input  logic [KEY_W-1:0] keyIn,
  input  logic [3:0]       roundCount,
  output logic [KEY_W-1:0] keyOut
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_sub, w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;
  logic [7:0]  w_rcon;

  // Round constant from the round number; out-of-range rounds give zero
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_rcon = 8'h00;
    case (roundCount)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_w0 = keyIn[127:96];
  assign w_w1 = keyIn[95:64];
  assign w_w2 = keyIn[63:32];
  assign w_w3 = keyIn[31:0];

  // RotWord, SubWord, then Rcon on the leading byte
  assign w_rot  = {w_w3[23:0], w_w3[31:24]};
  assign w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                   sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
  assign w_temp = w_sub ^ {w_rcon, 24'h000000};

  // Each new word chains off the one before it
  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign keyOut = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller. Accepts a cipher key, expands one round
// key per cycle through a single expansion-round instance, stores all
// Nr+1 round keys and serves them through a registered read port.
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int Nk = NK,
  parameter int Nr = NR
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [32*Nk-1:0]  key_in,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic              keys_valid,
  input  logic [3:0]        rd_addr,
  output logic [32*Nk-1:0]  rd_key
);

  localparam int         KW         = 32 * Nk;
  localparam logic [3:0] LAST_ROUND = 4'(Nr);

  state_t          r_state;
  logic [3:0]      r_round;
  logic [KW-1:0]   r_work_key;
  logic            r_keys_valid;
  logic            r_done;
  logic            r_busy;
  logic            r_key_ready;
  logic [KW-1:0]   r_rk [0:Nr];
  logic [KW-1:0]   r_rd_key;

  logic            w_accept;
  logic            w_wr_en;
  logic [3:0]      w_wr_addr;
  logic [KW-1:0]   w_wr_data;
  logic [KW-1:0]   w_round_key;

  PipelinedKeyExpansionRound u_round (
    .keyIn      (r_work_key),
    .roundCount (r_round),
    .keyOut     (w_round_key)
  );

  // clear always wins over an offered key
  assign w_accept = key_valid & r_key_ready & ~clear;

  // Storage write port: cipher key into slot 0 on acceptance, otherwise
  // the freshly expanded key into slot r_round while expanding
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_round;
    w_wr_data = w_round_key;
    if (w_accept) begin
      w_wr_en   = 1'b1;
      w_wr_addr = 4'd0;
      w_wr_data = key_in;
    end else if (!clear && r_state == ST_EXPAND) begin
      w_wr_en   = 1'b1;
    end
  end

  // Controller FSM with registered status outputs
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_round      <= 4'd0;
      r_work_key   <= '0;
      r_keys_valid <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_key_ready  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (clear) begin
        r_state      <= ST_IDLE;
        r_round      <= 4'd0;
        r_keys_valid <= 1'b0;
        r_busy       <= 1'b0;
        r_key_ready  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_READY: begin
            if (w_accept) begin
              r_state      <= ST_EXPAND;
              r_work_key   <= key_in;
              r_round      <= 4'd1;
              r_keys_valid <= 1'b0;
              r_busy       <= 1'b1;
              r_key_ready  <= 1'b0;
            end
          end
          ST_EXPAND: begin
            r_work_key <= w_round_key;
            if (r_round == LAST_ROUND) begin
              r_state      <= ST_READY;
              r_keys_valid <= 1'b1;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_key_ready  <= 1'b1;
            end else begin
              r_round <= r_round + 4'd1;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_round     <= 4'd0;
            r_busy      <= 1'b0;
            r_key_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  // Round-key storage, one write port; clear leaves contents untouched
  // NOTE: this array is reset explicitly because all entries must read as zero after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= Nr; i++) r_rk[i] <= '0;
    end else if (w_wr_en) begin
      r_rk[w_wr_addr] <= w_wr_data;
    end
  end

  // Registered read port; indices beyond the last round read as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_key <= '0;
    end else if (rd_addr <= LAST_ROUND) begin
      r_rd_key <= r_rk[rd_addr];
    end else begin
      r_rd_key <= '0;
    end
  end

  assign key_ready  = r_key_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign keys_valid = r_keys_valid;
  assign rd_key     = r_rd_key;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed testbench for key_schedule_ctrl using FIPS-197 and all-zero key
// schedules. Inputs change and outputs are sampled on the falling edge.
module tb_key_schedule_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] FIPS_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         clear;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  int total;
  int bad;

  key_schedule_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .clear      (clear),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_addr    (rd_addr),
    .rd_key     (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer a key for one edge; returns at the falling edge after acceptance
  task automatic offer_key(input logic [127:0] key);
    key_in    = key;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Falling edges until done is seen, or -1 when the budget runs out
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  // Registered read: present address, sample one cycle later
  task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
    rd_addr = a;
    @(negedge clk);
    d = rd_key;
  endtask

  task automatic test_reset();
    logic [127:0] d;
    rst = 1'b1; key_valid = 1'b0; clear = 1'b0; key_in = '0; rd_addr = 4'd0;
    repeat (2) @(negedge clk);
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_key_ready got=%b want=1", key_ready); end
    total++; if ({busy, done, keys_valid} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {busy, done, keys_valid}); end
    total++; if (rd_key !== '0) begin bad++; $display("FAIL reset_rd_key got=%h want=0", rd_key); end
    rst = 1'b0;
    @(negedge clk);
    read_rk(4'd10, d);
    total++; if (d !== '0) begin bad++; $display("FAIL reset_rk10 got=%h want=0", d); end
  endtask

  task automatic test_fips_vector();
    int n;
    logic [127:0] d;
    offer_key(FIPS_KEY);
    total++; if ({busy, key_ready} !== 2'b10) begin bad++; $display("FAIL fips_expand_flags got=%b want=10", {busy, key_ready}); end
    wait_done(n);
    total++; if (n !== 10) begin bad++; $display("FAIL fips_latency got=%0d want=10", n); end
    total++; if (keys_valid !== 1'b1) begin bad++; $display("FAIL fips_keys_valid got=%b want=1", keys_valid); end
    @(negedge clk);
    total++; if ({done, keys_valid, busy} !== 3'b010) begin bad++; $display("FAIL fips_done_pulse got=%b want=010", {done, keys_valid, busy}); end
    read_rk(4'd1, d);
    total++; if (d !== FIPS_RK[1]) begin bad++; $display("FAIL fips_rk1 got=%h want=%h", d, FIPS_RK[1]); end
    read_rk(4'd10, d);
    total++; if (d !== FIPS_RK[10]) begin bad++; $display("FAIL fips_rk10 got=%h want=%h", d, FIPS_RK[10]); end
  endtask

  task automatic test_read_sweep_rekey();
    int n;
    logic [127:0] d;
    logic [127:0] want;
    for (int a = 0; a < 16; a++) begin
      read_rk(4'(a), d);
      want = (a <= 10) ? FIPS_RK[a] : '0;
      total++; if (d !== want) begin bad++; $display("FAIL sweep_addr%0d got=%h want=%h", a, d, want); end
    end
    offer_key(ZERO_KEY);
    total++; if ({keys_valid, busy} !== 2'b01) begin bad++; $display("FAIL rekey_flags got=%b want=01", {keys_valid, busy}); end
    wait_done(n);
    total++; if (n !== 10) begin bad++; $display("FAIL rekey_latency got=%0d want=10", n); end
    read_rk(4'd1, d);
    total++; if (d !== ZERO_RK1) begin bad++; $display("FAIL rekey_rk1 got=%h want=%h", d, ZERO_RK1); end
    read_rk(4'd10, d);
    total++; if (d !== ZERO_RK10) begin bad++; $display("FAIL rekey_rk10 got=%h want=%h", d, ZERO_RK10); end
  endtask

  task automatic test_hold_valid();
    int n;
    int ready_high;
    logic [127:0] d;
    key_in    = FIPS_KEY;
    key_valid = 1'b1;
    @(negedge clk);
    key_in     = ZERO_KEY;
    n          = 0;
    ready_high = 0;
    while (done !== 1'b1 && n < 40) begin
      if (key_ready !== 1'b0) ready_high++;
      @(negedge clk);
      n++;
    end
    key_valid = 1'b0;
    total++; if (n !== 10) begin bad++; $display("FAIL hold_latency got=%0d want=10", n); end
    total++; if (ready_high !== 0) begin bad++; $display("FAIL hold_key_ready_cycles got=%0d want=0", ready_high); end
    read_rk(4'd10, d);
    total++; if (d !== FIPS_RK[10]) begin bad++; $display("FAIL hold_rk10 got=%h want=%h", d, FIPS_RK[10]); end
  endtask

  task automatic test_clear_mid();
    int dones;
    logic [127:0] d;
    offer_key(ZERO_KEY);
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if ({busy, keys_valid, done, key_ready} !== 4'b0001) begin bad++; $display("FAIL clear_flags got=%b want=0001", {busy, keys_valid, done, key_ready}); end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL clear_no_done got=%0d want=0", dones); end
    read_rk(4'd1, d);
    total++; if (d !== ZERO_RK1) begin bad++; $display("FAIL clear_rk1 got=%h want=%h", d, ZERO_RK1); end
    read_rk(4'd10, d);
    total++; if (d !== FIPS_RK[10]) begin bad++; $display("FAIL clear_rk10_kept got=%h want=%h", d, FIPS_RK[10]); end
  endtask

  task automatic test_clear_vs_valid();
    logic [127:0] d;
    key_in    = FIPS_KEY;
    key_valid = 1'b1;
    clear     = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    clear     = 1'b0;
    total++; if ({busy, key_ready, keys_valid} !== 3'b010) begin bad++; $display("FAIL clrval_flags got=%b want=010", {busy, key_ready, keys_valid}); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clrval_busy_later got=%b want=0", busy); end
    read_rk(4'd0, d);
    total++; if (d !== ZERO_KEY) begin bad++; $display("FAIL clrval_rk0 got=%h want=%h", d, ZERO_KEY); end
  endtask

  task automatic test_rst_mid();
    int n;
    logic [127:0] d;
    offer_key(FIPS_KEY);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({busy, done, keys_valid, key_ready} !== 4'b0001) begin bad++; $display("FAIL rst_mid_flags got=%b want=0001", {busy, done, keys_valid, key_ready}); end
    total++; if (rd_key !== '0) begin bad++; $display("FAIL rst_mid_rd_key got=%h want=0", rd_key); end
    @(negedge clk);
    rst = 1'b0;
    read_rk(4'd5, d);
    total++; if (d !== '0) begin bad++; $display("FAIL rst_mid_rk5 got=%h want=0", d); end
    offer_key(FIPS_KEY);
    wait_done(n);
    total++; if (n !== 10) begin bad++; $display("FAIL rst_mid_latency got=%0d want=10", n); end
    read_rk(4'd10, d);
    total++; if (d !== FIPS_RK[10]) begin bad++; $display("FAIL rst_mid_rk10 got=%h want=%h", d, FIPS_RK[10]); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fips_vector();
    test_read_sweep_rekey();
    test_hold_valid();
    test_clear_mid();
    test_clear_vs_valid();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
